// File: rtl/lpif_tx_control_dataflow.sv
// LPIF transmit beat buffer: masks invalid bytes, queues beats toward TX framing,
// and runs a TLP/DLLP framing checker that raises a sticky protocolError.
module lpif_tx_control_dataflow #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lp_irdy,
  input  logic [511:0] lp_data,
  input  logic [63:0]  lp_valid,
  input  logic [63:0]  lp_tlpstart,
  input  logic [63:0]  lp_tlpend,
  input  logic [63:0]  lp_tlpedb,
  input  logic [63:0]  lp_dllpstart,
  input  logic [63:0]  lp_dllpend,
  output logic         pl_trdy,
  output logic [511:0] packetData,
  output logic [63:0]  packetValid,
  output logic [63:0]  tlpstart,
  output logic [63:0]  tlpend,
  output logic [63:0]  edb,
  output logic [63:0]  dllpstart,
  output logic [63:0]  dllpend,
  output logic         txValid,
  input  logic         txReady,
  output logic         protocolError
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_TLP = 2'd1, IN_DLLP = 2'd2} chk_state_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  valid;
    logic [63:0]  tlps;
    logic [63:0]  tlpe;
    logic [63:0]  edb;
    logic [63:0]  dlls;
    logic [63:0]  dlle;
  } beat_t;

  beat_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  chk_state_t    r_state;
  logic          r_err;

  beat_t      w_wbeat;
  beat_t      w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic [2:0] w_scan;

  // Walks bytes 0..63 of a masked beat; returns {error, final checker state}.
  function automatic logic [2:0] scan_beat(input chk_state_t st_in, input beat_t b);
    chk_state_t st;
    logic       err;
    logic [4:0] m;
    st  = st_in;
    err = 1'b0;
    for (int k = 0; k < 64; k++) begin
      m = {b.tlps[k], b.tlpe[k], b.edb[k], b.dlls[k], b.dlle[k]};
      if (m != 5'b00000) begin
        case (st)
          IDLE: begin
            if (m == 5'b10000) st = IN_TLP;
            else if (m == 5'b00010) st = IN_DLLP;
            else begin err = 1'b1; st = IDLE; end
          end
          IN_TLP: begin
            if (m == 5'b01000 || m == 5'b00100 || m == 5'b01100) st = IDLE;
            else begin err = 1'b1; st = IDLE; end
          end
          IN_DLLP: begin
            if (m == 5'b00001) st = IDLE;
            else begin err = 1'b1; st = IDLE; end
          end
          default: begin err = 1'b1; st = IDLE; end
        endcase
      end
    end
    return {err, st};
  endfunction

  assign w_empty = (r_count == '0);
  assign txValid = ~w_empty;
  assign pl_trdy = (r_count < CNT_DEPTH);
  // Beats with no valid byte are accepted on the handshake but never stored.
  assign w_push  = lp_irdy & pl_trdy & (lp_valid != 64'd0);
  assign w_pop   = txValid & txReady;
  assign w_head  = r_mem[r_rptr];
  assign w_scan  = scan_beat(r_state, w_wbeat);

  always_comb begin
    w_wbeat.valid = lp_valid;
    w_wbeat.tlps  = lp_tlpstart  & lp_valid;
    w_wbeat.tlpe  = lp_tlpend    & lp_valid;
    w_wbeat.edb   = lp_tlpedb    & lp_valid;
    w_wbeat.dlls  = lp_dllpstart & lp_valid;
    w_wbeat.dlle  = lp_dllpend   & lp_valid;
    w_wbeat.data  = '0;
    for (int k = 0; k < 64; k++) begin
      w_wbeat.data[8*k +: 8] = lp_data[8*k +: 8] & {8{lp_valid[k]}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wptr] <= w_wbeat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else if (w_push) begin
      r_state <= chk_state_t'(w_scan[1:0]);
      r_err   <= r_err | w_scan[2];
    end
  end

  assign protocolError = r_err;
  assign packetData    = w_empty ? 512'd0 : w_head.data;
  assign packetValid   = w_empty ? 64'd0  : w_head.valid;
  assign tlpstart      = w_empty ? 64'd0  : w_head.tlps;
  assign tlpend        = w_empty ? 64'd0  : w_head.tlpe;
  assign edb           = w_empty ? 64'd0  : w_head.edb;
  assign dllpstart     = w_empty ? 64'd0  : w_head.dlls;
  assign dllpend       = w_empty ? 64'd0  : w_head.dlle;

endmodule

// File: tb/tb_lpif_tx_control_dataflow.sv
// Directed bench for lpif_tx_control_dataflow: a per-cycle vector table plus
// hand-written sequences for sticky error, reset while full and end variants.
module tb_lpif_tx_control_dataflow;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] T0  = 64'h0000_0000_0000_0001;
  localparam logic [63:0] T63 = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         lp_irdy;
  logic [511:0] lp_data;
  logic [63:0]  lp_valid, lp_tlpstart, lp_tlpend, lp_tlpedb, lp_dllpstart, lp_dllpend;
  logic         pl_trdy;
  logic [511:0] packetData;
  logic [63:0]  packetValid, tlpstart, tlpend, edb, dllpstart, dllpend;
  logic         txValid, txReady, protocolError;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lpif_tx_control_dataflow #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
    .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend), .lp_tlpedb(lp_tlpedb),
    .lp_dllpstart(lp_dllpstart), .lp_dllpend(lp_dllpend), .pl_trdy(pl_trdy),
    .packetData(packetData), .packetValid(packetValid), .tlpstart(tlpstart),
    .tlpend(tlpend), .edb(edb), .dllpstart(dllpstart), .dllpend(dllpend),
    .txValid(txValid), .txReady(txReady), .protocolError(protocolError)
  );

  typedef struct {
    logic        rst, irdy, rdy;
    logic [63:0] valid;
    logic [7:0]  fill;
    logic [63:0] tlps, tlpe, dlls;
    logic        e_trdy, e_txv, e_perr;
    logic [63:0] e_pv, e_tlps, e_dlls;
    logic [7:0]  e_fill;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_data(input logic [63:0] pv, input logic [7:0] f);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 64; k++) if (pv[k]) d[8*k +: 8] = f;
    return d;
  endfunction

  task automatic drive(input logic rst, input logic irdy, input logic rdy,
                       input logic [63:0] valid, input logic [7:0] fill,
                       input logic [63:0] ts, input logic [63:0] te, input logic [63:0] ed,
                       input logic [63:0] ds, input logic [63:0] de);
    @(negedge clk);
    reset        = rst;
    lp_irdy      = irdy;
    txReady      = rdy;
    lp_valid     = valid;
    lp_data      = {64{fill}};
    lp_tlpstart  = ts;
    lp_tlpend    = te;
    lp_tlpedb    = ed;
    lp_dllpstart = ds;
    lp_dllpend   = de;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; lp_irdy = 1'b0; txReady = 1'b0; lp_data = '0; lp_valid = '0;
    lp_tlpstart = '0; lp_tlpend = '0; lp_tlpedb = '0; lp_dllpstart = '0; lp_dllpend = '0;

    //          rst  irdy rdy   valid   fill   tlps tlpe  dlls      trdy txv  perr  pv      otlps odlls  efill
    vecs[0]  = '{1'b1,1'b0,1'b0, 64'h0,  8'h00, 64'h0,64'h0,64'h0,   1'b1,1'b0,1'b0, 64'h0,  64'h0,64'h0,  8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b1, ALL,    8'h11, T0,  T63,  64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h11};
    vecs[2]  = '{1'b0,1'b0,1'b1, 64'h0,  8'h00, 64'h0,64'h0,64'h0,   1'b1,1'b0,1'b0, 64'h0,  64'h0,64'h0,  8'h00};
    vecs[3]  = '{1'b0,1'b1,1'b0, ALL,    8'h21, T0,  T63,  64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h21};
    vecs[4]  = '{1'b0,1'b1,1'b0, ALL,    8'h22, T0,  T63,  64'h0,   1'b0,1'b1,1'b0, ALL,    T0,   64'h0,  8'h21};
    vecs[5]  = '{1'b0,1'b1,1'b0, ALL,    8'h23, T0,  T63,  64'h0,   1'b0,1'b1,1'b0, ALL,    T0,   64'h0,  8'h21};
    vecs[6]  = '{1'b0,1'b1,1'b1, ALL,    8'h23, T0,  T63,  64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h22};
    vecs[7]  = '{1'b0,1'b1,1'b1, ALL,    8'h23, T0,  T63,  64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h23};
    vecs[8]  = '{1'b0,1'b0,1'b1, 64'h0,  8'h00, 64'h0,64'h0,64'h0,   1'b1,1'b0,1'b0, 64'h0,  64'h0,64'h0,  8'h00};
    vecs[9]  = '{1'b0,1'b1,1'b0, 64'hFF, 8'hAA, 64'h0,64'h0,64'h400, 1'b1,1'b1,1'b0, 64'hFF, 64'h0,64'h0,  8'hAA};
    vecs[10] = '{1'b0,1'b1,1'b1, ALL,    8'h33, T0,  T63,  64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h33};
    vecs[11] = '{1'b0,1'b0,1'b1, 64'h0,  8'h00, 64'h0,64'h0,64'h0,   1'b1,1'b0,1'b0, 64'h0,  64'h0,64'h0,  8'h00};
    vecs[12] = '{1'b0,1'b1,1'b0, 64'h0,  8'h44, T0,  64'h0,64'h0,   1'b1,1'b0,1'b0, 64'h0,  64'h0,64'h0,  8'h00};
    vecs[13] = '{1'b0,1'b1,1'b1, ALL,    8'h55, T0,  64'h0,64'h0,   1'b1,1'b1,1'b0, ALL,    T0,   64'h0,  8'h55};
    vecs[14] = '{1'b0,1'b1,1'b1, ALL,    8'h56, 64'h0,64'h0,64'h20,  1'b1,1'b1,1'b1, ALL,    64'h0,64'h20, 8'h56};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].irdy, vecs[i].rdy, vecs[i].valid, vecs[i].fill,
            vecs[i].tlps, vecs[i].tlpe, 64'h0, vecs[i].dlls, 64'h0);
      chk($sformatf("v%0d pl_trdy", i),       512'(pl_trdy),       512'(vecs[i].e_trdy));
      chk($sformatf("v%0d txValid", i),       512'(txValid),       512'(vecs[i].e_txv));
      chk($sformatf("v%0d protocolError", i), 512'(protocolError), 512'(vecs[i].e_perr));
      chk($sformatf("v%0d packetValid", i),   512'(packetValid),   512'(vecs[i].e_pv));
      chk($sformatf("v%0d tlpstart", i),      512'(tlpstart),      512'(vecs[i].e_tlps));
      chk($sformatf("v%0d dllpstart", i),     512'(dllpstart),     512'(vecs[i].e_dlls));
      chk($sformatf("v%0d packetData", i),    packetData,          exp_data(vecs[i].e_pv, vecs[i].e_fill));
    end

    // protocolError must hold through ten clean packets
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, ALL, 8'(8'h60 + i), T0, T63, 64'h0, 64'h0, 64'h0);
      chk($sformatf("sticky%0d protocolError", i), 512'(protocolError), 512'(1'b1));
      chk($sformatf("sticky%0d txValid", i),       512'(txValid),       512'(1'b1));
      chk($sformatf("sticky%0d packetData", i),    packetData,          exp_data(ALL, 8'(8'h60 + i)));
    end
    drive(1'b0, 1'b0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk("drain txValid", 512'(txValid), 512'(1'b0));
    chk("drain protocolError", 512'(protocolError), 512'(1'b1));

    // Reset while full and mid-packet; the coinciding push and pop are discarded
    drive(1'b0, 1'b1, 1'b0, ALL, 8'h70, T0, 64'h0, 64'h0, 64'h0, 64'h0);
    drive(1'b0, 1'b1, 1'b0, ALL, 8'h71, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk("full pl_trdy", 512'(pl_trdy), 512'(1'b0));
    chk("full txValid", 512'(txValid), 512'(1'b1));
    drive(1'b1, 1'b1, 1'b1, ALL, 8'h72, T0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk("rst txValid", 512'(txValid), 512'(1'b0));
    chk("rst pl_trdy", 512'(pl_trdy), 512'(1'b1));
    chk("rst protocolError", 512'(protocolError), 512'(1'b0));
    chk("rst packetData", packetData, 512'd0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk("postrst txValid", 512'(txValid), 512'(1'b0));
    chk("postrst pl_trdy", 512'(pl_trdy), 512'(1'b1));
    drive(1'b0, 1'b1, 1'b1, ALL, 8'h73, T0, T63, 64'h0, 64'h0, 64'h0);
    chk("postrst tlp protocolError", 512'(protocolError), 512'(1'b0));
    chk("postrst tlp packetData", packetData, exp_data(ALL, 8'h73));

    // edb closes a TLP, dllpend closes a DLLP, start+end in one byte is a violation
    drive(1'b0, 1'b1, 1'b1, ALL, 8'h74, T0, 64'h0, T63, 64'h0, 64'h0);
    chk("edb end protocolError", 512'(protocolError), 512'(1'b0));
    chk("edb end output", 512'(edb), 512'(T63));
    drive(1'b0, 1'b1, 1'b1, ALL, 8'h75, 64'h0, 64'h0, 64'h0, T0, 64'h2);
    chk("dllp protocolError", 512'(protocolError), 512'(1'b0));
    chk("dllp dllpstart", 512'(dllpstart), 512'(T0));
    chk("dllp dllpend", 512'(dllpend), 512'(64'h2));
    drive(1'b0, 1'b1, 1'b1, ALL, 8'h76, 64'h8, 64'h8, 64'h0, 64'h0, 64'h0);
    chk("samebyte protocolError", 512'(protocolError), 512'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk("final txValid", 512'(txValid), 512'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpif_tx_control_dataflow.md
LPIF_TX_CONTROL_DATAFLOW -- requirements
Module: lpif_tx_control_dataflow

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: number of beat-buffer entries, a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port lp_irdy, input, 1 bit: link layer has a beat to transfer.
REQ-005 The block SHALL have port lp_data, input, 512 bits: link-layer data, byte k = bits [8k+7:8k].
REQ-006 The block SHALL have port lp_valid, input, 64 bits: per-byte valid.
REQ-007 The block SHALL have ports lp_tlpstart, lp_tlpend, lp_tlpedb, lp_dllpstart and lp_dllpend, input, 64 bits each: per-byte framing markers.
REQ-008 The block SHALL have port pl_trdy, output, 1 bit: the block can accept a beat.
REQ-009 The block SHALL have port packetData, output, 512 bits: buffered data toward TX framing.
REQ-010 The block SHALL have port packetValid, output, 64 bits: per-byte valid of the head beat.
REQ-011 The block SHALL have ports tlpstart, tlpend, edb, dllpstart and dllpend, output, 64 bits each: framing markers of the head beat.
REQ-012 The block SHALL have port txValid, output, 1 bit: a head beat is presented.
REQ-013 The block SHALL have port txReady, input, 1 bit: TX framing consumes the head beat.
REQ-014 The block SHALL have port protocolError, output, 1 bit: sticky framing-violation flag.

Function
REQ-015 An input beat SHALL be accepted when lp_irdy=1 and pl_trdy=1 at a rising edge.
REQ-016 An output beat SHALL be popped when txValid=1 and txReady=1 at a rising edge.
REQ-017 pl_trdy SHALL equal (count < DEPTH), derived from registered count only, never from txReady.
REQ-018 txValid SHALL equal (count != 0).
REQ-019 count SHALL increment on push-only, decrement on pop-only, and hold when both or neither occur.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-021 Data and marker bytes whose lp_valid bit is 0 SHALL be written as 0; packetData and marker outputs carry only valid-byte content.
REQ-022 An accepted beat with lp_valid==0 SHALL be dropped: no push, no count change, no checker update, and pl_trdy is unaffected.
REQ-023 Outputs SHALL be driven directly from the head entry, so a beat pushed into an empty buffer at edge N is presented at txValid=1 in the cycle after edge N (latency 1).
REQ-024 When full, pushing and popping SHALL NOT both occur; pl_trdy is 0, and a pop frees a slot so pl_trdy=1 in the following cycle.
REQ-025 When count==0, packetData, packetValid and all marker outputs SHALL be 0.
REQ-026 The framing checker FSM SHALL have states IDLE, IN_TLP and IN_DLLP.
REQ-027 The checker SHALL scan valid bytes of each pushed beat in order from byte 0 to byte 63.
REQ-028 tlpstart in IDLE SHALL move the checker to IN_TLP, and dllpstart in IDLE SHALL move it to IN_DLLP.
REQ-029 tlpend or edb in IN_TLP, and dllpend in IN_DLLP, SHALL move the checker to IDLE.
REQ-030 Any other marker, including a start in a non-IDLE state or a mismatched end, SHALL set protocolError and move the checker to IDLE.
REQ-031 A start and its end in the same byte SHALL be a violation.
REQ-032 Checker state SHALL carry across beats, and its next state SHALL be computed from the fully scanned beat within one cycle.
REQ-033 protocolError SHALL stay 1 until reset.
REQ-034 Beats SHALL be buffered and forwarded regardless of protocolError.

Reset
REQ-035 When reset=1 at an edge, count, pointers and protocolError SHALL become 0, the checker SHALL become IDLE, and pl_trdy SHALL be 1 and txValid 0 in the next cycle.
REQ-036 A push or pop coinciding with reset=1 SHALL be discarded, including when reset is asserted mid-packet with the buffer full.
REQ-037 Buffer data storage SHALL need no reset, since outputs are masked to 0 by REQ-025.

Verification
REQ-038 The bench SHALL cover single beat: lp_valid=all-ones, tlpstart bit0, tlpend bit63, txReady=1 -> txValid=1 one cycle later with identical data, count returns to 0, protocolError=0.
REQ-039 The bench SHALL cover backpressure: txReady=0 with 3 beats offered and DEPTH=2 -> exactly 2 accepted, pl_trdy=0; then txReady=1 -> beats exit in order and pl_trdy returns to 1.
REQ-040 The bench SHALL cover masking: lp_valid=64'h00FF, lp_data all 0xAA, dllpstart bit 10 -> packetData bytes 0-7 = 0xAA, bytes 8-63 = 0, dllpstart output = 0, checker stays IDLE.
REQ-041 The bench SHALL cover an empty beat: lp_irdy=1 with lp_valid=0 -> txValid stays 0 and count stays 0.
REQ-042 The bench SHALL cover violations: tlpstart bit0 then dllpstart bit5 in the next beat -> protocolError=1 and it holds through 10 further clean packets.
REQ-043 The bench SHALL cover reset while full: reset=1 for one edge -> count=0, txValid=0, pl_trdy=1, protocolError=0 in the next cycle.
